// File: rtl/imem_loader.sv
// imem_loader: assembles host bytes into 32-bit words, writes them to instruction memory,
// and holds the core in reset until the whole image has been written.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [31:0]       asm_q, asm_d, wr_data_q, wr_data_d, asm_nx;
  assign asm_nx = BIG_ENDIAN ? {asm_q[23:0], byte_data} : {byte_data, asm_q[31:8]};
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    asm_d     = asm_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        if (len_words == '0) state_d = DONE;
        else begin
          len_d   = len_words;
          addr_d  = '0;
          wcnt_d  = '0;
          bcnt_d  = '0;
          state_d = RECV;
        end
      end
      RECV: if (byte_valid) begin
        asm_d  = asm_nx;
        bcnt_d = bcnt_q + 2'd1;
        // the write-port registers only change here, so they hold outside WRITE
        if (bcnt_q == 2'd3) begin
          wr_data_d = asm_nx;
          wr_addr_d = addr_q;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_q + 1'b1 == len_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      wcnt_q    <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      asm_q     <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      wcnt_q    <= wcnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      asm_q     <= asm_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign byte_ready   = state_q == RECV;
  assign imem_wr_en   = state_q == WRITE;
  assign busy         = state_q == RECV || state_q == WRITE;
  assign done         = state_q == DONE;
  assign cpu_rstn     = state_q == DONE;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer-side counterpart to the instruction memory the single-cycle MIPS core reads from. It accepts a byte stream from a host over a valid/ready handshake and assembles 32-bit instruction words. It writes those words to consecutive word addresses of instruction memory. It holds the core in reset (cpu_rstn) until a complete program image has been written.

Parameters:
ADDR_W, 8, instruction-memory word-address width; maximum image is 2^ADDR_W words
BIG_ENDIAN, 1, 1: first byte of each group lands in [31:24] (MIPS order); 0: first byte lands in [7:0]

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE
len_words  input  ADDR_W+1  number of words to load, sampled with start; range 0..2^ADDR_W
byte_valid  input  1  host byte available
byte_data  input  8  host byte
byte_ready  output  1  loader accepts byte this cycle
imem_wr_en  output  1  instruction-memory write strobe, one cycle per word
imem_wr_addr  output  ADDR_W  word address of the write
imem_wr_data  output  32  assembled instruction word
cpu_rstn  output  1  active-low reset to the core; high only in DONE
busy  output  1  high in RECV or WRITE
done  output  1  high in DONE

Behaviour:
- FSM states: IDLE, RECV, WRITE, DONE. All outputs are registered or decoded from state only. No input-to-output combinational path.
- Reset (asynchronous, rstn=0): state=IDLE. byte_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, cpu_rstn=0, busy=0, done=0. Internal byte counter=0, word counter=0.
- IDLE: cpu_rstn=0.
  - start=1 and len_words=0: next state DONE.
  - start=1 and len_words>0: latch len_words, clear the address, word counter and byte counter; next state RECV.
- RECV: byte_ready=1. A byte is accepted on a cycle where byte_valid && byte_ready.
  - BIG_ENDIAN=1: shift the assembly register left by 8 and insert the byte in [7:0].
  - BIG_ENDIAN=0: shift right by 8 and insert the byte in [31:24].
  - The byte counter increments mod 4. On the 4th accepted byte, next state is WRITE. byte_valid low means a stall; no state change.
- WRITE, exactly one cycle:
  - imem_wr_en=1, with imem_wr_addr and imem_wr_data stable and valid. byte_ready=0.
  - The next cycle increments the address (ADDR_W bits, wraps to 0 after 2^ADDR_W-1) and the word counter.
  - If the incremented word counter equals the latched length, go to DONE; otherwise go to RECV.
- DONE: cpu_rstn=1, done=1, byte_ready=0.
  - start=1 re-enters the load sequence exactly as from IDLE. cpu_rstn falls to 0 on the same edge.
- Latency: imem_wr_en asserts the cycle after the 4th byte is accepted. Sustained throughput is 5 cycles per word with byte_valid held high.
- start is ignored in RECV and WRITE. len_words is ignored except when start is accepted.
- imem_wr_data and imem_wr_addr hold their last values outside WRITE. imem_wr_en is never high outside WRITE.
- Reset asserted mid-load aborts immediately: no further writes, cpu_rstn=0. Memory contents already written are left as is.
- A full image (len_words=2^ADDR_W) writes addresses 0..2^ADDR_W-1 once each, then enters DONE. The address wraps to 0.

Test Plan:
- Reset: hold rstn=0 → all outputs 0. Release rstn with no start for 20 cycles → state IDLE, cpu_rstn=0, byte_ready=0.
- Basic load: start, len_words=2, bytes 20 08 00 05 8C 09 00 04 with continuous valid → exactly two write strobes, addr0=0x20080005 and addr1=0x8C090004, 5 cycles apart. Then done=1 and cpu_rstn=1.
- Stalls and start while busy: same image with random byte_valid gaps, plus a start pulse while busy=1 → identical writes, no extra strobes, the start has no effect.
- Zero length, then reload: len_words=0 → DONE one cycle after start, no writes. A new start with len_words=1 → cpu_rstn drops, one write, back to DONE.
- Reset mid-load: assert rstn after 6 accepted bytes → only addr0 written, all outputs at reset values. A subsequent load restarts at addr 0.
- Little-endian and full image: BIG_ENDIAN=0 with bytes 05 00 08 20 → word 0x20080005. ADDR_W=2 with len_words=4 → addresses 0,1,2,3, then DONE.
